// File: rtl/res_fifo_pkg.sv
// Shared types and default sizes for the residual-path FIFO.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package res_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_FM_DEPTH   = 64;
    localparam int DEF_DEPTH      = 16;

    // One residual word: FM_DEPTH signed channel values.
    typedef logic signed [DEF_DATA_WIDTH-1:0] res_word_t [DEF_FM_DEPTH];

    // Occupancy 0..DEPTH needs one bit more than the pointers.
    typedef logic [$clog2(DEF_DEPTH):0] count_t;

endpackage

// File: rtl/res_fifo_ptr.sv
// Pointer, occupancy and sticky-error control for res_fifo.
// Latency: acceptance strobes are combinational; pointers/count/flags update on the next edge.
// Backpressure: wr_ready drops when full unless a read is accepted in the same cycle.
//
// Ports: clk/rst (async active-high); wr_valid/rd_req/err_clr requests in;
// wr_acc/rd_acc acceptance strobes and wr_ptr/rd_ptr addresses out to the storage;
// wr_ready, count, full, empty, overflow, underflow status out.
module res_fifo_ptr #(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    input  logic                  rd_req,
    input  logic                  err_clr,
    output logic                  wr_acc,
    output logic                  rd_acc,
    output logic                  wr_ready,
    output logic [ADDR_WIDTH-1:0] wr_ptr,
    output logic [ADDR_WIDTH-1:0] rd_ptr,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    output logic                  underflow
);

    // Flags come straight off the count register so wr_valid never reaches them.
    assign full  = (count == (ADDR_WIDTH+1)'(DEPTH));
    assign empty = (count == '0);

    assign rd_acc   = rd_req & ~empty;
    // A full FIFO still takes a write when a read frees a slot this cycle.
    assign wr_acc   = wr_valid & (~full | rd_acc);
    assign wr_ready = ~full | rd_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (rd_acc) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + (ADDR_WIDTH+1)'(1);
                2'b01:   count <= count - (ADDR_WIDTH+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Clear first, then set: a new error in the clear cycle is kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (err_clr) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end
            if (wr_valid & ~wr_acc) overflow  <= 1'b1;
            if (rd_req & empty)     underflow <= 1'b1;
        end
    end

endmodule

// File: rtl/res_fifo.sv
// Residual-path FIFO: stores layer-input activations and replays them in order to the BN/residual-add stage.
// Latency: rd_req sampled at an edge -> res/res_valid valid after that edge (one cycle, no write bypass).
// Backpressure: wr_ready low when full and no read accepted; refused writes/reads only set sticky flags.
//
// Ports: clk, rst (async active-high); wr_valid/wr_data/wr_ready write side;
// rd_req (BN data_in_valid) and res/res_valid read side; count/full/empty occupancy;
// err_clr, overflow, underflow sticky error handling.
module res_fifo
    import res_fifo_pkg::*;
#(
    parameter int   DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int   FM_DEPTH   = DEF_FM_DEPTH,
    parameter int   DEPTH      = DEF_DEPTH,
    localparam int  ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_valid,
    input  logic signed [DATA_WIDTH-1:0] wr_data [FM_DEPTH],
    output logic                         wr_ready,
    input  logic                         rd_req,
    output logic signed [DATA_WIDTH-1:0] res [FM_DEPTH],
    output logic                         res_valid,
    output logic [ADDR_WIDTH:0]          count,
    output logic                         full,
    output logic                         empty,
    input  logic                         err_clr,
    output logic                         overflow,
    output logic                         underflow
);

    logic                  wr_acc;
    logic                  rd_acc;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;

    // Storage is deliberately not reset; count guards every read.
    logic signed [DATA_WIDTH-1:0] mem [DEPTH][FM_DEPTH];

    res_fifo_ptr #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ptr (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .rd_req    (rd_req),
        .err_clr   (err_clr),
        .wr_acc    (wr_acc),
        .rd_acc    (rd_acc),
        .wr_ready  (wr_ready),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= wr_data;
    end

    // Read reads the old slot content: a same-cycle write to an empty FIFO is not forwarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            for (int k = 0; k < FM_DEPTH; k++) res[k] <= '0;
        end else begin
            res_valid <= rd_acc;
            if (rd_acc) res <= mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_res_fifo.sv
module tb_res_fifo;
    import res_fifo_pkg::*;

    logic      clk = 1'b0;
    logic      rst = 1'b1;
    logic      wr_valid = 1'b0;
    res_word_t wr_data;
    logic      wr_ready;
    logic      rd_req = 1'b0;
    res_word_t res;
    logic      res_valid;
    count_t    count;
    logic      full;
    logic      empty;
    logic      err_clr = 1'b0;
    logic      overflow;
    logic      underflow;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    res_fifo dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .rd_req    (rd_req),
        .res       (res),
        .res_valid (res_valid),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .err_clr   (err_clr),
        .overflow  (overflow),
        .underflow (underflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Channel k carries val+k so misordered channels are caught too.
    task automatic set_word(input int val);
        for (int k = 0; k < DEF_FM_DEPTH; k++) wr_data[k] = 16'(val + k);
    endtask

    task automatic push(input int val);
        wr_valid = 1'b1;
        set_word(val);
        cyc();
        wr_valid = 1'b0;
    endtask

    // One read pulse; checks the word and a single-cycle res_valid.
    task automatic pop_check(input string tag, input int val);
        rd_req = 1'b1;
        cyc();
        rd_req = 1'b0;
        check({tag, "_vld"}, 32'(res_valid), 32'd1);
        check({tag, "_ch0"}, 32'(res[0]), 32'(16'(val)));
        check({tag, "_ch63"}, 32'(res[63]), 32'(16'(val + 63)));
    endtask

    initial begin
        set_word(0);
        #2;
        // Reset state
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res0", 32'(res[0]), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_unf", 32'(underflow), 32'd0);
        cyc();
        rst = 1'b0;
        cyc();

        // Three writes then three reads
        push('h11); push('h22); push('h33);
        check("w3_count", 32'(count), 32'd3);
        pop_check("r1", 'h11);
        cyc();
        check("r1_vld_drop", 32'(res_valid), 32'd0);
        check("r1_hold", 32'(res[0]), 32'h11);
        pop_check("r2", 'h22);
        pop_check("r3", 'h33);
        check("r3_count", 32'(count), 32'd0);
        check("r3_empty", 32'(empty), 32'd1);

        // Fill to 16
        for (int i = 1; i <= 16; i++) push(i);
        check("fill_full", 32'(full), 32'd1);
        check("fill_wr_ready", 32'(wr_ready), 32'd0);
        check("fill_count", 32'(count), 32'd16);
        push(99);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd16);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        check("ovf_clr", 32'(overflow), 32'd0);

        // Simultaneous write and read while full
        wr_valid = 1'b1;
        rd_req   = 1'b1;
        set_word('hAA);
        #1;
        check("full_rw_wr_ready", 32'(wr_ready), 32'd1);
        cyc();
        wr_valid = 1'b0;
        rd_req   = 1'b0;
        check("full_rw_res", 32'(res[0]), 32'd1);
        check("full_rw_count", 32'(count), 32'd16);
        check("full_rw_ovf", 32'(overflow), 32'd0);
        for (int i = 2; i <= 16; i++) pop_check($sformatf("drain%0d", i), i);
        pop_check("drain_aa", 'hAA);
        check("drain_empty", 32'(empty), 32'd1);

        // Underflow and err_clr priority
        rd_req = 1'b1;
        cyc();
        rd_req = 1'b0;
        check("unf_set", 32'(underflow), 32'd1);
        check("unf_res_valid", 32'(res_valid), 32'd0);
        check("unf_res_hold", 32'(res[0]), 32'hAA);
        err_clr = 1'b1;
        cyc();
        check("unf_clr", 32'(underflow), 32'd0);
        rd_req = 1'b1;
        cyc();
        rd_req  = 1'b0;
        err_clr = 1'b0;
        check("unf_set_wins", 32'(underflow), 32'd1);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;

        // Empty FIFO, same-cycle write and read: no bypass
        wr_valid = 1'b1;
        rd_req   = 1'b1;
        set_word('h55);
        cyc();
        wr_valid = 1'b0;
        rd_req   = 1'b0;
        check("nobyp_unf", 32'(underflow), 32'd1);
        check("nobyp_count", 32'(count), 32'd1);
        check("nobyp_vld", 32'(res_valid), 32'd0);
        pop_check("nobyp_rd", 'h55);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;

        // Pointer wrap with interleaved pairs
        for (int v = 100; v < 140; v++) begin
            push(v);
            check("wrap_cnt1", 32'(count), 32'd1);
            pop_check("wrap", v);
            check("wrap_cnt0", 32'(count), 32'd0);
        end
        check("wrap_ovf", 32'(overflow), 32'd0);
        check("wrap_unf", 32'(underflow), 32'd0);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 6; i++) push(200 + i);
        pop_check("pre_rst", 200);
        check("pre_rst_count", 32'(count), 32'd5);
        #2 rst = 1'b1;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_empty", 32'(empty), 32'd1);
        check("arst_res0", 32'(res[0]), 32'd0);
        check("arst_res_valid", 32'(res_valid), 32'd0);
        cyc();
        rst = 1'b0;
        cyc();
        rd_req = 1'b1;
        cyc();
        rd_req = 1'b0;
        check("post_rst_unf", 32'(underflow), 32'd1);
        check("post_rst_vld", 32'(res_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
